// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_pkg
// Description : Shared types and helpers for the programmable clock divider.
//               Holds the FSM state encoding, the minimum legal divisor and
//               the divisor/high-time clamp function.
// Revision    : 1.0 - initial release
// ============================================================================
package clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int MIN_DIV = 2;

  // Working width of the clamp helper; counter widths up to this are supported.
  localparam int CLAMP_W = 32;

  // Returns {N, H} made legal: N >= MIN_DIV and 1 <= H <= N-1.
  function automatic logic [2*CLAMP_W-1:0] clamp_nh(
    input logic [CLAMP_W-1:0] n_in,
    input logic [CLAMP_W-1:0] h_in
  );
    logic [CLAMP_W-1:0] n;
    logic [CLAMP_W-1:0] h;
    n = (n_in < CLAMP_W'(MIN_DIV)) ? CLAMP_W'(MIN_DIV) : n_in;
    if (h_in == '0) begin
      h = CLAMP_W'(1);
    end else if (h_in >= n) begin
      h = n - CLAMP_W'(1);
    end else begin
      h = h_in;
    end
    return {n, h};
  endfunction

endpackage
`default_nettype wire

// File: rtl/clkdiv_cfg_reg.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_cfg_reg
// Description : Divisor/high-time configuration store. Clamps requested
//               values, keeps a pending copy until the top level says it may
//               take effect, and pulses div_ack when the active pair changes.
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n        - clock, async active-low reset
//               ld, div_in,       - load strobe and requested N/H
//               high_in
//               bypass            - load goes straight to the active pair
//               apply             - period boundary: commit pending pair
//               act_n, act_h      - currently active N/H
//               div_ack           - one-cycle pulse after active pair changes
// ============================================================================
module clkdiv_cfg_reg
  import clkdiv_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int DEFAULT_DIV  = 4,
  parameter int DEFAULT_HIGH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [CNT_W-1:0] div_in,
  input  logic [CNT_W-1:0] high_in,
  input  logic             bypass,
  input  logic             apply,
  output logic [CNT_W-1:0] act_n,
  output logic [CNT_W-1:0] act_h,
  output logic             div_ack
);

  logic [CNT_W-1:0] w_clamp_n;
  logic [CNT_W-1:0] w_clamp_h;

  logic [CNT_W-1:0] pend_n_q, pend_n_d;
  logic [CNT_W-1:0] pend_h_q, pend_h_d;
  logic             pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0] act_n_q, act_n_d;
  logic [CNT_W-1:0] act_h_q, act_h_d;
  logic             ack_q, ack_d;

  assign w_clamp_n = CNT_W'(clamp_nh(CLAMP_W'(div_in), CLAMP_W'(high_in)) >> CLAMP_W);
  assign w_clamp_h = CNT_W'(clamp_nh(CLAMP_W'(div_in), CLAMP_W'(high_in)));

  always_comb begin
    pend_n_d   = pend_n_q;
    pend_h_d   = pend_h_q;
    pend_vld_d = pend_vld_q;
    act_n_d    = act_n_q;
    act_h_d    = act_h_q;
    ack_d      = 1'b0;
    if (ld && bypass) begin
      act_n_d    = w_clamp_n;
      act_h_d    = w_clamp_h;
      pend_vld_d = 1'b0;
      ack_d      = 1'b1;
    end else begin
      if (apply && pend_vld_q) begin
        act_n_d    = pend_n_q;
        act_h_d    = pend_h_q;
        pend_vld_d = 1'b0;
        ack_d      = 1'b1;
      end
      // A load on the boundary edge itself waits for the following boundary;
      // a load while already pending simply overwrites (latest wins).
      if (ld) begin
        pend_n_d   = w_clamp_n;
        pend_h_d   = w_clamp_h;
        pend_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_n_q   <= CNT_W'(DEFAULT_DIV);
      pend_h_q   <= CNT_W'(DEFAULT_HIGH);
      pend_vld_q <= 1'b0;
      act_n_q    <= CNT_W'(DEFAULT_DIV);
      act_h_q    <= CNT_W'(DEFAULT_HIGH);
      ack_q      <= 1'b0;
    end else begin
      pend_n_q   <= pend_n_d;
      pend_h_q   <= pend_h_d;
      pend_vld_q <= pend_vld_d;
      act_n_q    <= act_n_d;
      act_h_q    <= act_h_d;
      ack_q      <= ack_d;
    end
  end

  assign act_n   = act_n_q;
  assign act_h   = act_h_q;
  assign div_ack = ack_q;

endmodule
`default_nettype wire

// File: rtl/clkdiv_prog.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_prog
// Description : Programmable clock divider. Generates a registered divided
//               clock with runtime divisor N and high-time H, and a one-cycle
//               tick on each div_clk rise for use as a clock enable.
// Revision    : 1.0 - initial release
// Build macro : CLKDIV_SYNC_LOAD_EN
//               defined   - loads in RUN/DRAIN wait for the period boundary
//               undefined - loads apply on the next edge and restart the
//                           count (current period truncated)
// Ports       : clk, rst_n        - clock, async active-low reset
//               en                - run request
//               div_ld            - load strobe for div_in/high_in
//               div_in, high_in   - requested N and H
//               div_ack           - pulse when new N/H take effect
//               div_clk           - divided clock (registered)
//               tick              - pulse coincident with each div_clk rise
//               busy              - state is not IDLE
// ============================================================================
module clkdiv_prog
  import clkdiv_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int DEFAULT_DIV  = 4,
  parameter int DEFAULT_HIGH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             div_ld,
  input  logic [CNT_W-1:0] div_in,
  input  logic [CNT_W-1:0] high_in,
  output logic             div_ack,
  output logic             div_clk,
  output logic             tick,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_clk_q, div_clk_d;
  logic             tick_q, tick_d;

  logic [CNT_W-1:0] w_act_n;
  logic [CNT_W-1:0] w_act_h;
  logic [CNT_W-1:0] w_last;
  logic [CNT_W-1:0] w_rise;
  logic             w_wrap;
  logic             w_bypass;
  logic             w_restart;
  logic             w_apply;
  logic             w_run_next;

  assign w_last  = w_act_n - CNT_W'(1);
  assign w_rise  = w_act_n - w_act_h;
  assign w_wrap  = (cnt_q == w_last);
  assign w_apply = (state_q != IDLE) && w_wrap;

`ifdef CLKDIV_SYNC_LOAD_EN
  // Only an idle divider takes a load immediately; the counter is already 0.
  assign w_bypass = (state_q == IDLE);
`else
  // Every load takes effect at once and restarts the period.
  assign w_bypass = 1'b1;
`endif
  assign w_restart = div_ld && w_bypass;

  clkdiv_cfg_reg #(
    .CNT_W        (CNT_W),
    .DEFAULT_DIV  (DEFAULT_DIV),
    .DEFAULT_HIGH (DEFAULT_HIGH)
  ) u_cfg (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld      (div_ld),
    .div_in  (div_in),
    .high_in (high_in),
    .bypass  (w_bypass),
    .apply   (w_apply),
    .act_n   (w_act_n),
    .act_h   (w_act_h),
    .div_ack (div_ack)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      // Re-enable during DRAIN keeps the running count, so no glitch.
      DRAIN: begin
        if (en) begin
          state_d = RUN;
        end else if (w_wrap) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if ((state_q != IDLE) && !w_restart && !w_wrap) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Outputs are qualified by the next state so the DRAIN->IDLE edge
    // forces div_clk low even though the final count is in the high phase.
    w_run_next = (state_d != IDLE);
    div_clk_d  = w_run_next && (cnt_q >= w_rise);
    tick_d     = w_run_next && (cnt_q == w_rise);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_clk_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_clk_q <= div_clk_d;
      tick_q    <= tick_d;
    end
  end

  assign div_clk = div_clk_q;
  assign tick    = tick_q;
  assign busy    = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_clkdiv_prog
// Description : Directed self-checking bench for clkdiv_prog. Each task
//               drives one scenario and compares outputs against
//               hand-computed waveforms. Edge Ek means the k-th rising edge
//               after the IDLE->RUN edge E0; outputs are sampled 1 ns later.
//               Build macro CLKDIV_SYNC_LOAD_EN selects the matching tests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clkdiv_prog;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       div_ld;
  logic [7:0] div_in;
  logic [7:0] high_in;
  logic       div_ack;
  logic       div_clk;
  logic       tick;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  clkdiv_prog #(
    .CNT_W        (8),
    .DEFAULT_DIV  (4),
    .DEFAULT_HIGH (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .div_ld  (div_ld),
    .div_in  (div_in),
    .high_in (high_in),
    .div_ack (div_ack),
    .div_clk (div_clk),
    .tick    (tick),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; div_ld = 1'b0; div_in = 8'd0; high_in = 8'd0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Load N/H while idle (takes effect on the next edge in both builds).
  task automatic idle_load(input logic [7:0] n, input logic [7:0] h);
    div_ld = 1'b1; div_in = n; high_in = h;
    step();
    div_ld = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; div_ld = 1'b1; div_in = 8'd8; high_in = 8'd4;
    step();
    step();
    checks++; if (div_clk !== 1'b0) begin failures++; $display("FAIL reset_div_clk: got %b want 0", div_clk); end
    checks++; if (tick !== 1'b0)    begin failures++; $display("FAIL reset_tick: got %b want 0", tick); end
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (div_ack !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b want 0", div_ack); end
    do_reset();
    step();
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_default();
    logic [12:1] exp_div;
    exp_div = 12'b1000_1000_1000;
    do_reset();
    en = 1'b1;
    step();  // E0
    checks++; if (busy !== 1'b1)    begin failures++; $display("FAIL dflt_busy_e0: got %b want 1", busy); end
    checks++; if (div_clk !== 1'b0) begin failures++; $display("FAIL dflt_div_e0: got %b want 0", div_clk); end
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++; if (div_clk !== exp_div[k]) begin failures++; $display("FAIL dflt_div_e%0d: got %b want %b", k, div_clk, exp_div[k]); end
      checks++; if (tick !== exp_div[k])    begin failures++; $display("FAIL dflt_tick_e%0d: got %b want %b", k, tick, exp_div[k]); end
      checks++; if (busy !== 1'b1)          begin failures++; $display("FAIL dflt_busy_e%0d: got %b want 1", k, busy); end
    end
  endtask

  task automatic test_clamp();
    logic [4:1] exp_a;
    logic [8:1] exp_b;
    exp_a = 4'b1010;        // N=1,H=0 -> N=2,H=1
    exp_b = 8'b1011_1110;   // N=6,H=9 -> N=6,H=5
    do_reset();
    idle_load(8'd1, 8'd0);
    checks++; if (div_ack !== 1'b1) begin failures++; $display("FAIL clamp_ack_a: got %b want 1", div_ack); end
    en = 1'b1;
    step();
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (div_clk !== exp_a[k]) begin failures++; $display("FAIL clamp_a_div_e%0d: got %b want %b", k, div_clk, exp_a[k]); end
    end
    do_reset();
    idle_load(8'd6, 8'd9);
    en = 1'b1;
    step();
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++; if (div_clk !== exp_b[k]) begin failures++; $display("FAIL clamp_b_div_e%0d: got %b want %b", k, div_clk, exp_b[k]); end
    end
  endtask

  task automatic test_en_drop();
    logic [13:7] exp_div;
    exp_div = 7'b1000011;   // E13..E7
    do_reset();
    idle_load(8'd8, 8'd4);
    en = 1'b1;
    for (int k = 0; k <= 5; k++) step();
    checks++; if (tick !== 1'b1) begin failures++; $display("FAIL drop_tick_e5: got %b want 1", tick); end
    en = 1'b0;
    step();  // E6: RUN->DRAIN
    checks++; if (busy !== 1'b1 || div_clk !== 1'b1) begin failures++; $display("FAIL drop_e6: busy=%b div=%b want 1 1", busy, div_clk); end
    step();  // E7: cnt 6->7
    checks++; if (busy !== 1'b1 || div_clk !== 1'b1) begin failures++; $display("FAIL drop_e7: busy=%b div=%b want 1 1", busy, div_clk); end
    step();  // E8: cnt==7 -> IDLE
    checks++; if (busy !== 1'b0 || div_clk !== 1'b0) begin failures++; $display("FAIL drop_e8: busy=%b div=%b want 0 0", busy, div_clk); end

    do_reset();
    idle_load(8'd8, 8'd4);
    en = 1'b1;
    for (int k = 0; k <= 5; k++) step();
    en = 1'b0;
    step();  // E6 into DRAIN
    en = 1'b1;
    for (int k = 7; k <= 13; k++) begin
      step();
      checks++; if (div_clk !== exp_div[k] || busy !== 1'b1) begin failures++; $display("FAIL redrain_e%0d: div=%b busy=%b want %b 1", k, div_clk, busy, exp_div[k]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [8:1] exp_div;
    exp_div = 8'b1000_1000;
    do_reset();
    idle_load(8'd8, 8'd4);
    en = 1'b1;
    for (int k = 0; k <= 5; k++) step();
`ifdef CLKDIV_SYNC_LOAD_EN
    div_ld = 1'b1; div_in = 8'd3; high_in = 8'd1;
`endif
    step();  // E6: high phase (load pending in the deferred build)
    div_ld = 1'b0;
    checks++; if (div_clk !== 1'b1) begin failures++; $display("FAIL rmid_pre_div: got %b want 1", div_clk); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({div_clk, tick, busy, div_ack} !== 4'b0000) begin failures++; $display("FAIL rmid_async: div/tick/busy/ack=%b want 0000", {div_clk, tick, busy, div_ack}); end
    step();
    rst_n = 1'b1;
    step();  // E0 with defaults
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++; if (div_clk !== exp_div[k]) begin failures++; $display("FAIL rmid_div_e%0d: got %b want %b", k, div_clk, exp_div[k]); end
      checks++; if (div_ack !== 1'b0)       begin failures++; $display("FAIL rmid_ack_e%0d: got %b want 0", k, div_ack); end
    end
  endtask

`ifdef CLKDIV_SYNC_LOAD_EN
  task automatic test_sync_load();
    logic [11:1] exp_div;
    exp_div = 11'b011_1110_0000;   // N=10,H=5 after the wrap
    do_reset();
    en = 1'b1;
    step(); step();                // E0, E1
    div_ld = 1'b1; div_in = 8'd10; high_in = 8'd5;
    step();                        // E2: captured as pending
    div_ld = 1'b0;
    checks++; if (div_ack !== 1'b0 || div_clk !== 1'b0) begin failures++; $display("FAIL sync_e2: ack=%b div=%b want 0 0", div_ack, div_clk); end
    step();                        // E3
    checks++; if (div_ack !== 1'b0 || div_clk !== 1'b0) begin failures++; $display("FAIL sync_e3: ack=%b div=%b want 0 0", div_ack, div_clk); end
    step();                        // E4: old period completes, wrap applies
    checks++; if (div_ack !== 1'b1 || div_clk !== 1'b1) begin failures++; $display("FAIL sync_e4: ack=%b div=%b want 1 1", div_ack, div_clk); end
    for (int k = 1; k <= 11; k++) begin
      step();
      checks++; if (div_clk !== exp_div[k] || div_ack !== 1'b0) begin failures++; $display("FAIL sync_new_k%0d: div=%b ack=%b want %b 0", k, div_clk, div_ack, exp_div[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:1] exp_div;
    exp_div = 7'b0111110;          // N=6,H=5 after the wrap
    do_reset();
    en = 1'b1;
    step(); step();
    div_ld = 1'b1; div_in = 8'd1; high_in = 8'd0;
    step();                        // E2
    div_in = 8'd6; high_in = 8'd9;
    step();                        // E3: overwrites pending
    div_ld = 1'b0;
    checks++; if (div_ack !== 1'b0) begin failures++; $display("FAIL b2b_ack_e3: got %b want 0", div_ack); end
    step();                        // E4: wrap
    checks++; if (div_ack !== 1'b1) begin failures++; $display("FAIL b2b_ack_e4: got %b want 1", div_ack); end
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++; if (div_clk !== exp_div[k] || div_ack !== 1'b0) begin failures++; $display("FAIL b2b_k%0d: div=%b ack=%b want %b 0", k, div_clk, div_ack, exp_div[k]); end
    end
  endtask
`else
  task automatic test_async_load();
    logic [8:2] exp_div;
    exp_div = 7'b1001000;          // E8..E2
    do_reset();
    idle_load(8'd8, 8'd4);
    en = 1'b1;
    step(); step();                // E0, E1: cnt=1
    div_ld = 1'b1; div_in = 8'd3; high_in = 8'd1;
    step();                        // E2: cnt forced 0, N=3
    div_ld = 1'b0;
    checks++; if (div_ack !== 1'b1) begin failures++; $display("FAIL async_ack_e2: got %b want 1", div_ack); end
    checks++; if (div_clk !== exp_div[2]) begin failures++; $display("FAIL async_div_e2: got %b want %b", div_clk, exp_div[2]); end
    for (int k = 3; k <= 8; k++) begin
      step();
      checks++; if (div_clk !== exp_div[k] || div_ack !== 1'b0) begin failures++; $display("FAIL async_e%0d: div=%b ack=%b want %b 0", k, div_clk, div_ack, exp_div[k]); end
    end
    checks++; if (tick !== 1'b1) begin failures++; $display("FAIL async_tick_e8: got %b want 1", tick); end
  endtask

  task automatic test_back_to_back();
    logic [10:4] exp_div;
    exp_div = 7'b0111000;          // E10..E4, N=6,H=3
    do_reset();
    en = 1'b1;
    step(); step();                // E0, E1
    div_ld = 1'b1; div_in = 8'd5; high_in = 8'd2;
    step();                        // E2
    checks++; if (div_ack !== 1'b1) begin failures++; $display("FAIL b2b_ack_e2: got %b want 1", div_ack); end
    div_in = 8'd6; high_in = 8'd3;
    step();                        // E3
    div_ld = 1'b0;
    checks++; if (div_ack !== 1'b1) begin failures++; $display("FAIL b2b_ack_e3: got %b want 1", div_ack); end
    for (int k = 4; k <= 10; k++) begin
      step();
      checks++; if (div_clk !== exp_div[k] || div_ack !== 1'b0) begin failures++; $display("FAIL b2b_e%0d: div=%b ack=%b want %b 0", k, div_clk, div_ack, exp_div[k]); end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; en = 1'b0; div_ld = 1'b0; div_in = 8'd0; high_in = 8'd0;
    #2;
    test_reset();
    test_default();
    test_clamp();
    test_en_drop();
    test_reset_mid();
`ifdef CLKDIV_SYNC_LOAD_EN
    test_sync_load();
`else
    test_async_load();
`endif
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
